uart_tx_engine: RTL
===================

# uart_tx_engine

Transmit half of the APB UART: sits directly downstream of the APB UART register file and consumes each byte written to THR. Buffers bytes in a TX FIFO, then serializes them onto SOUT as asynchronous frames using the divisor (DLM:DLL) and line-control (LCR) settings held by the register file. Returns the THRE/TEMT status the register file reports in LSR.

## Interface
Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, 2..256.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- wr_valid  in  1  one-cycle strobe: APB write to THR accepted this cycle
- wr_data  in  8  byte written to THR
- fifo_clr  in  1  synchronous FIFO flush (FCR[2]); does not abort the frame in flight
- divisor  in  16  {DLM, DLL}; bit period = 16*divisor CLK cycles
- lcr  in  7  LCR[6:0]: [1:0] word length 5..8, [2] stop bits, [3] parity enable, [4] even parity, [5] stick parity, [6] break
- SOUT  out  1  serial output, idle high
- thre  out  1  FIFO empty
- temt  out  1  FIFO empty and shifter idle
- fifo_full  out  1  count == FIFO_DEPTH
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse: write dropped

## Operation
- FIFO: write when wr_valid and not full; read pointer advances on pop by the FSM. A write when full is dropped and pulses overflow; the exception is a write when full in the same cycle as a pop, which is accepted (count unchanged). Pointers wrap modulo FIFO_DEPTH.
- fifo_clr: pointers and count go to 0 on the next edge; this has priority over a same-cycle wr_valid (write lost, no overflow pulse) and over a same-cycle pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO not empty and divisor != 0, pop the head byte, latch the byte, divisor and lcr[5:0], and go to START.
  - START: SOUT=0 for one bit period, then DATA.
  - DATA: shift LSB first for 5+lcr[1:0] bits. Then go to PARITY if parity is enabled, else STOP.
  - PARITY: the bit is XOR of the data bits, inverted for odd parity (lcr[4]=0). With stick parity, the bit is !lcr[4].
  - STOP: SOUT=1 for 1 bit period (lcr[2]=0) or 2 bit periods (lcr[2]=1; 1.5 is not supported). Then go to IDLE.
- Bit timer: 20-bit down-counter loaded with 16*divisor-1; the bit ends when it reaches 0.
- divisor == 0: no new frame starts; a frame already in flight continues with its latched divisor.
- Divisor and lcr[5:0] changes take effect only at the next frame start.
- Break: lcr[6] is live, not latched. It forces SOUT=0 while set, and the FSM keeps running underneath.
- thre = (count==0); temt = thre && state==IDLE.

## Timing
- Reset values: SOUT=1, thre=1, temt=1, fifo_full=0, fifo_count=0, overflow=0; FSM in IDLE; FIFO pointers at 0.
- SOUT, overflow and all status outputs are registered.
- Latency for a write sampled at edge E, with the FIFO empty, the FSM idle and divisor != 0:
  - the pop occurs at edge E+1;
  - SOUT falls at edge E+2.
- Frame length = (1 + data bits + parity bit + stop bits) * 16*divisor cycles.
- Back-to-back frames: the last STOP bit ends at edge T. If the FIFO is not empty, the pop occurs at T and the next start bit begins at T+1, giving a one-cycle gap.
- Reset asserted mid-frame: SOUT goes high immediately (asynchronous) and the FIFO contents are lost.

## Configuration
- UART_TX_PARITY_EN
  - Defined: parity support as specified above.
  - Undefined: lcr[5:3] are ignored, the PARITY state and parity logic are removed, and frames never carry a parity bit.

## Test plan
- Reset: RSTN low mid-frame -> SOUT=1, thre=1, temt=1, fifo_count=0 while asserted and after release.
- Basic 8N1: divisor=1, lcr=0x03, write 0x55 -> SOUT falls 2 cycles after the write; bits 1,0,1,0,1,0,1,0 each 16 cycles; stop bit 16 cycles; temt rises after the stop bit.
- Parity and word length: lcr=0x1A (7 bits, even parity, 1 stop), write 0x07 -> 7 data bits then parity=1. lcr=0x3A (stick parity, even) -> parity bit=0.
- FIFO full: with divisor=0, write 17 bytes -> fifo_full=1, fifo_count=16, overflow pulses once. Then set divisor=1 -> 16 frames transmitted in order, 1-cycle gap between frames.
- Simultaneous events:
  - write while full in the same cycle as a pop -> accepted, no overflow;
  - fifo_clr with a same-cycle write -> fifo_count=0, the frame in flight completes, no further frames.
- Break and live changes: set lcr[6] mid-frame -> SOUT=0 until cleared. Change divisor 1->2 mid-frame -> the current frame keeps 16-cycle bits and the next frame uses 32-cycle bits.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: TX FIFO plus asynchronous frame serializer for the APB UART transmit path.
// Latency: write sampled at edge E pops at E+1 and drives the start bit from E+2; queued frames are separated by one idle cycle.
// Backpressure: none upstream; a write to a full FIFO is dropped and flagged on overflow unless a pop frees a slot that cycle.
//
// Ports:
//   CLK, RSTN        clock, asynchronous active-low reset
//   wr_valid/wr_data one-cycle THR write strobe and byte
//   fifo_clr         synchronous FIFO flush; the frame already on the line finishes
//   divisor          {DLM,DLL}, bit period = 16*divisor cycles, 0 holds off new frames
//   lcr              [1:0] word length-5, [2] two stop bits, [3] parity enable,
//                    [4] even parity, [5] stick parity, [6] break (live, not latched)
//   SOUT             serial line, idle high
//   thre/temt        FIFO empty / FIFO empty and serializer idle
//   fifo_full, fifo_count, overflow  FIFO status, overflow is a one-cycle pulse
//
// Build option: define UART_TX_PARITY_EN to support the parity bit; without it lcr[5:3] are ignored.
module uart_tx_engine #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        CLK,
   input  logic                        RSTN,
   input  logic                        wr_valid,
   input  logic [7:0]                  wr_data,
   input  logic                        fifo_clr,
   input  logic [15:0]                 divisor,
   input  logic [6:0]                  lcr,
   output logic                        SOUT,
   output logic                        thre,
   output logic                        temt,
   output logic                        fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_n;
   logic          full, pop, push;
   logic [7:0]    head;

   logic [2:0]    state, state_n;
   logic [19:0]   timer;
   logic [2:0]    bit_cnt;
   logic [2:0]    last_bit;
   logic [7:0]    shift;
   logic [15:0]   div_lat;
   logic [1:0]    wl_lat;
   logic          stop2_lat;
   logic          bit_end;
   logic          line_bit;

   assign full     = (fifo_count == DEPTH_C);
   assign head     = mem[rd_ptr];
   // Flush wins over a pop: the head byte is discarded, not sent.
   assign pop      = (state == IDLE) && (fifo_count != '0) && (divisor != '0) && !fifo_clr;
   // A full FIFO still accepts a write when the same cycle pops a slot free.
   assign push     = wr_valid && !fifo_clr && (!full || pop);
   assign bit_end  = (timer == '0);
   assign last_bit = 3'd4 + {1'b0, wl_lat};

`ifdef UART_TX_PARITY_EN
   logic       pen_lat, par_lat;
   logic [7:0] data_mask;
   logic       par_calc;
   // Parity is computed from the popped byte while it is latched, so only the bit itself is stored.
   assign data_mask = 8'hFF >> (2'd3 - lcr[1:0]);
   assign par_calc  = lcr[5] ? ~lcr[4]
                    : (lcr[4] ? ^(head & data_mask) : ~^(head & data_mask));
`else
   logic unused_lcr;
   assign unused_lcr = ^lcr[5:3];
`endif

   // ---------------- TX FIFO ----------------
   always_comb begin
      count_n = fifo_count;
      if (fifo_clr)
         count_n = '0;
      else if (push && !pop)
         count_n = fifo_count + 1'b1;
      else if (pop && !push)
         count_n = fifo_count - 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         thre       <= 1'b1;
         temt       <= 1'b1;
         fifo_full  <= 1'b0;
      end else begin
         if (fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_count <= count_n;
         overflow   <= wr_valid && !fifo_clr && full && !pop;
         // Status is registered from next-state values so it lines up with fifo_count.
         thre       <= (count_n == '0);
         fifo_full  <= (count_n == DEPTH_C);
         temt       <= (count_n == '0) && (state_n == IDLE);
      end
   end

   // ---------------- serializer ----------------
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (pop) state_n = START;
         START: if (bit_end) state_n = DATA;
         DATA:  if (bit_end && bit_cnt == last_bit)
`ifdef UART_TX_PARITY_EN
                   state_n = pen_lat ? PARITY : STOP;
         PARITY: if (bit_end) state_n = STOP;
`else
                   state_n = STOP;
`endif
         // bit_cnt counts the first of two stop bits.
         STOP:  if (bit_end && (!stop2_lat || bit_cnt != 3'd0)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      line_bit = 1'b1;
      case (state)
         START:  line_bit = 1'b0;
         DATA:   line_bit = shift[0];
`ifdef UART_TX_PARITY_EN
         PARITY: line_bit = par_lat;
`endif
         default: line_bit = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state     <= IDLE;
         timer     <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         div_lat   <= '0;
         wl_lat    <= '0;
         stop2_lat <= 1'b0;
`ifdef UART_TX_PARITY_EN
         pen_lat   <= 1'b0;
         par_lat   <= 1'b0;
`endif
         SOUT      <= 1'b1;
      end else begin
         state <= state_n;
         // Break is applied on the registered line only; the frame keeps running underneath.
         SOUT  <= lcr[6] ? 1'b0 : line_bit;
         if (pop) begin
            shift     <= head;
            div_lat   <= divisor;
            wl_lat    <= lcr[1:0];
            stop2_lat <= lcr[2];
`ifdef UART_TX_PARITY_EN
            pen_lat   <= lcr[3];
            par_lat   <= par_calc;
`endif
            timer     <= {divisor, 4'b0000} - 20'd1;
            bit_cnt   <= '0;
         end else if (state != IDLE) begin
            if (!bit_end) begin
               timer <= timer - 1'b1;
            end else begin
               timer <= {div_lat, 4'b0000} - 20'd1;
               if (state == DATA)
                  shift <= {1'b0, shift[7:1]};
               bit_cnt <= (state_n != state) ? 3'd0 : bit_cnt + 1'b1;
            end
         end
      end
   end

endmodule
